// File: rtl/ram_arbiter_if.sv
// Request/acknowledge and RAM-port bundle between two clients, the arbiter and one RAM.
// Latency: wires only; no state lives here.
// Backpressure: clients hold req with stable fields until ack; the RAM side has none.
// Ports: req/we/addr/wdata per client in; ack/rvalid per client and shared rdata out;
//        ram_addr_in/ram_data_in/ram_w (write port), ram_addr_out/ram_r (read port), ram_data_out.
interface ram_arbiter_if #(
    parameter int n = 4,
    parameter int m = 4
);
    logic         req0;
    logic         req1;
    logic         we0;
    logic         we1;
    logic [n-1:0] addr0;
    logic [n-1:0] addr1;
    logic [m-1:0] wdata0;
    logic [m-1:0] wdata1;
    logic         ack0;
    logic         ack1;
    logic         rvalid0;
    logic         rvalid1;
    logic [m-1:0] rdata;
    logic [n-1:0] ram_addr_in;
    logic [m-1:0] ram_data_in;
    logic         ram_w;
    logic [n-1:0] ram_addr_out;
    logic         ram_r;
    logic [m-1:0] ram_data_out;

    // Arbiter side.
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_data_out,
        output ack0, ack1, rvalid0, rvalid1, rdata,
               ram_addr_in, ram_data_in, ram_w, ram_addr_out, ram_r
    );

    // Client + RAM side.
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_data_out,
        input  ack0, ack1, rvalid0, rvalid1, rdata,
               ram_addr_in, ram_data_in, ram_w, ram_addr_out, ram_r
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer granting a dual-port RAM to one of two requesters.
// Latency: ack (and rvalid/rdata for reads) 2 cycles after req is sampled; 1 transaction per 3 cycles.
// Backpressure: loser keeps req high and is served next; requests during ACCESS/DONE are not queued.
// Ports: clk, rst (synchronous, active high); bus = ram_arbiter_if.slave carrying both
//        client handshakes and the RAM write/read ports. All outputs are registered.
module ram_arbiter #(
    parameter int n = 4,
    parameter int m = 4
) (
    input  logic         clk,
    input  logic         rst,
    ram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         prio_q, prio_d;       // port that wins when both request
    logic         id_q, id_d;           // latched winner
    logic         we_q, we_d;
    logic [n-1:0] addr_q, addr_d;       // feeds both RAM address ports directly
    logic [m-1:0] wdata_q, wdata_d;
    logic         ram_w_q, ram_w_d;
    logic         ram_r_q, ram_r_d;
    logic [1:0]   ack_q, ack_d;
    logic [1:0]   rvalid_q, rvalid_d;
    logic [m-1:0] rdata_q, rdata_d;
    logic         win;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            id_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ram_w_q  <= 1'b0;
            ram_r_q  <= 1'b0;
            ack_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            id_q     <= id_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ram_w_q  <= ram_w_d;
            ram_r_q  <= ram_r_d;
            ack_q    <= ack_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        id_d     = id_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ram_w_d  = 1'b0;   // strobes only ever last the single ACCESS cycle
        ram_r_d  = 1'b0;
        ack_d    = '0;
        rvalid_d = '0;
        rdata_d  = rdata_q;
        win      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    win     = (bus.req0 && bus.req1) ? prio_q : bus.req1;
                    id_d    = win;
                    we_d    = win ? bus.we1    : bus.we0;
                    addr_d  = win ? bus.addr1  : bus.addr0;
                    wdata_d = win ? bus.wdata1 : bus.wdata0;
                    // Strobe rises on the same edge as the address, so the RAM
                    // never sees a strobe with a moving address.
                    ram_w_d = we_d;
                    ram_r_d = !we_d;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                ack_d[id_q] = 1'b1;
                if (!we_q) begin
                    rvalid_d[id_q] = 1'b1;
                    rdata_d        = bus.ram_data_out;
                end
                // Toggle away from every grant, contended or not.
                prio_d  = ~id_q;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ack0         = ack_q[0];
    assign bus.ack1         = ack_q[1];
    assign bus.rvalid0      = rvalid_q[0];
    assign bus.rvalid1      = rvalid_q[1];
    assign bus.rdata        = rdata_q;
    assign bus.ram_addr_in  = addr_q;
    assign bus.ram_addr_out = addr_q;
    assign bus.ram_data_in  = wdata_q;
    assign bus.ram_w        = ram_w_q;
    assign bus.ram_r        = ram_r_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus random traffic vs a transaction-level model.
// Latency: expects ack 2 cycles after the sampled request, IDLE again 1 cycle later.
// Backpressure: bench requesters follow the hold-until-ack rule; loser keeps requesting.
module tb_ram_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ram_arbiter_if #(.n(4), .m(4)) bus();

    ram_arbiter #(.n(4), .m(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural RAM attached to the arbiter.
    logic [3:0] ram_mem [16];
    always @(posedge clk) if (bus.ram_w) ram_mem[bus.ram_addr_in] <= bus.ram_data_in;
    assign bus.ram_data_out = ram_mem[bus.ram_addr_out];

    // Transaction-level reference model.
    logic [3:0] ref_mem [16];
    bit         ref_prio;
    logic [3:0] ref_rdata;

    // Requester state.
    bit         rq  [2];
    bit         rwe [2];
    logic [3:0] radr[2];
    logic [3:0] rwd [2];

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.req0   = rq[0];   bus.req1   = rq[1];
        bus.we0    = rwe[0];  bus.we1    = rwe[1];
        bus.addr0  = radr[0]; bus.addr1  = radr[1];
        bus.wdata0 = rwd[0];  bus.wdata1 = rwd[1];
    endtask

    task automatic set_req(input int p, input bit we, input logic [3:0] a, input logic [3:0] d);
        rq[p] = 1'b1; rwe[p] = we; radr[p] = a; rwd[p] = d;
    endtask

    // Called at a negedge inside an IDLE cycle; returns at a negedge of the next IDLE cycle.
    task automatic step_txn(input string tag);
        int         w;
        logic [1:0] onehot;
        drive();
        w      = (rq[0] && rq[1]) ? int'(ref_prio) : (rq[1] ? 1 : 0);
        onehot = 2'b01 << w;
        @(negedge clk);  // ACCESS
        chk({tag, ":acc_w"}, bus.ram_w, rwe[w]);
        chk({tag, ":acc_r"}, bus.ram_r, !rwe[w]);
        if (rwe[w]) begin
            chk({tag, ":acc_addr_in"}, bus.ram_addr_in, radr[w]);
            chk({tag, ":acc_data_in"}, bus.ram_data_in, rwd[w]);
        end else begin
            chk({tag, ":acc_addr_out"}, bus.ram_addr_out, radr[w]);
        end
        chk({tag, ":acc_no_ack"}, {bus.ack1, bus.ack0}, 2'b00);
        @(negedge clk);  // DONE
        if (rwe[w]) ref_mem[radr[w]] = rwd[w];
        else        ref_rdata = ref_mem[radr[w]];
        chk({tag, ":ack"},    {bus.ack1, bus.ack0}, onehot);
        chk({tag, ":rvalid"}, {bus.rvalid1, bus.rvalid0}, rwe[w] ? 2'b00 : onehot);
        chk({tag, ":rdata"},  bus.rdata, ref_rdata);
        chk({tag, ":done_strobes"}, {bus.ram_w, bus.ram_r}, 2'b00);
        ref_prio = (w == 0);
        rq[w]    = 1'b0;
        drive();
        @(negedge clk);  // IDLE
        chk({tag, ":idle_ack"}, {bus.ack1, bus.ack0, bus.rvalid1, bus.rvalid0, bus.ram_w, bus.ram_r}, 6'd0);
    endtask

    // Continuous RAM-port checks, sampled 1 time unit after each rising edge.
    bit         rst_e;
    bit         prev_strobe = 1'b0;
    logic [3:0] prev_ai, prev_ao, prev_di;
    always @(posedge clk) begin
        rst_e = rst;
        #1;
        if (prev_strobe && !rst_e)
            chk("mon_strobe_then_ack", bus.ack0 | bus.ack1, 1'b1);
        if (bus.ram_w || bus.ram_r) begin
            chk("mon_strobe_one_cycle", prev_strobe, 1'b0);
            chk("mon_strobe_exclusive", bus.ram_w & bus.ram_r, 1'b0);
        end
        if (!rst_e && (bus.ram_addr_in !== prev_ai || bus.ram_addr_out !== prev_ao
                       || bus.ram_data_in !== prev_di))
            chk("mon_port_change_on_access", bus.ram_w | bus.ram_r, 1'b1);
        prev_strobe = bus.ram_w | bus.ram_r;
        prev_ai     = bus.ram_addr_in;
        prev_ao     = bus.ram_addr_out;
        prev_di     = bus.ram_data_in;
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            ram_mem[i] = 4'h0;
            ref_mem[i] = 4'h0;
        end
        ref_prio  = 1'b0;
        ref_rdata = 4'h0;
        for (int p = 0; p < 2; p++) set_req(p, 1'b0, 4'h0, 4'h0);
        drive();
        rst = 1'b1;

        // Reset with both requesting: everything stays quiet.
        repeat (2) begin
            @(negedge clk);
            chk("reset_outputs", {bus.ack1, bus.ack0, bus.rvalid1, bus.rvalid0, bus.ram_w, bus.ram_r,
                                  bus.rdata, bus.ram_addr_in, bus.ram_addr_out, bus.ram_data_in}, 22'd0);
        end
        rst = 1'b0;
        step_txn("post_reset_p0");
        step_txn("post_reset_p1");

        // Write then read across ports.
        set_req(0, 1'b1, 4'h3, 4'hA);
        step_txn("wr_p0");
        set_req(1, 1'b0, 4'h3, 4'h0);
        step_txn("rd_p1");

        // Preload, ending on a port-1 grant so port 0 leads the contention run.
        set_req(0, 1'b1, 4'h1, 4'h5);
        step_txn("preload1");
        set_req(1, 1'b1, 4'h2, 4'h6);
        step_txn("preload2");
        set_req(0, 1'b0, 4'h1, 4'h0);
        set_req(1, 1'b0, 4'h2, 4'h0);
        for (int i = 0; i < 4; i++) begin
            step_txn("contention");
            if (!rq[0]) rq[0] = 1'b1;
            else        rq[1] = 1'b1;
        end
        rq[0] = 1'b0; rq[1] = 1'b0;

        // Fairness after a lone grant.
        set_req(1, 1'b1, 4'h7, 4'h9);
        step_txn("lone_p1");
        set_req(0, 1'b0, 4'h7, 4'h0);
        set_req(1, 1'b0, 4'h3, 4'h0);
        step_txn("fair_after_lone");
        step_txn("fair_remaining");

        // Reset during ACCESS of a port-0 read.
        set_req(0, 1'b0, 4'h1, 4'h0);
        drive();
        @(negedge clk);
        chk("midrst_access_r", bus.ram_r, 1'b1);
        rst   = 1'b1;
        rq[0] = 1'b0;
        drive();
        @(negedge clk);
        chk("midrst_ack_rvalid", {bus.ack0, bus.rvalid0}, 2'b00);
        chk("midrst_ram_r", bus.ram_r, 1'b0);
        chk("midrst_rdata", bus.rdata, 4'h0);
        rst       = 1'b0;
        ref_prio  = 1'b0;
        ref_rdata = 4'h0;

        // Address sweep: write ~addr everywhere, read it all back.
        for (int a = 0; a < 16; a++) begin
            set_req(int'($urandom_range(0, 1)), 1'b1, 4'(a), ~4'(a));
            step_txn("sweep_wr");
        end
        for (int a = 0; a < 16; a++) begin
            set_req(int'($urandom_range(0, 1)), 1'b0, 4'(a), 4'h0);
            step_txn("sweep_rd");
        end

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            for (int p = 0; p < 2; p++)
                if (!rq[p] && $urandom_range(0, 1) == 1)
                    set_req(p, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if (!rq[0] && !rq[1])
                set_req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            step_txn("random");
        end
        if (rq[0] || rq[1]) step_txn("drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
